// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the cache requester slice.
// FSM state encoding, response codes and the fill timeout rule.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LK_WAIT,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WR_MEM,
    S_FILL,
    S_RESP
  } req_state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int unsigned STAT_W = 16;

  // A zero timeout selects a limit wide enough for a full CLOCK sweep.
  function automatic int unsigned fill_limit(
    input int unsigned k,
    input int unsigned timeout
  );
    return (timeout == 0) ? (2 * k + 2) : timeout;
  endfunction

endpackage

// File: rtl/cache_req_stats.sv
// cache_req_stats: saturating hit/miss/timeout event counters.
// Only instantiated when CACHE_REQ_STATS_EN is defined.
module cache_req_stats
  import cache_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              hit_i,
  input  logic              miss_i,
  input  logic              timeout_i,
  output logic [STAT_W-1:0] hits_o,
  output logic [STAT_W-1:0] misses_o,
  output logic [STAT_W-1:0] timeouts_o
);

  logic [STAT_W-1:0] hits_q;
  logic [STAT_W-1:0] misses_q;
  logic [STAT_W-1:0] timeouts_q;

  // Count one event per pulse, sticking at all-ones.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hits_q     <= '0;
      misses_q   <= '0;
      timeouts_q <= '0;
    end else begin
      if (hit_i && hits_q != '1)
        hits_q <= hits_q + 1'b1;
      if (miss_i && misses_q != '1)
        misses_q <= misses_q + 1'b1;
      if (timeout_i && timeouts_q != '1)
        timeouts_q <= timeouts_q + 1'b1;
    end
  end

  assign hits_o     = hits_q;
  assign misses_o   = misses_q;
  assign timeouts_o = timeouts_q;

endmodule

// File: rtl/cache_requester.sv
// cache_requester: single-outstanding ch1 initiator, write-through stores.
// Define CACHE_REQ_STATS_EN to add the stat_* counter outputs.
module cache_requester
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned LINE_WIDTH   = 32,
  parameter int unsigned K            = 2,
  parameter int unsigned FILL_TIMEOUT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ch1_in_addr,
  output logic [LINE_WIDTH-1:0] ch1_in_val,
  output logic                  ch1_read,
  output logic                  ch1_write,
  input  logic                  ch1_hit,
  input  logic [LINE_WIDTH-1:0] ch1_out_val,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data
`ifdef CACHE_REQ_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_hits,
  output logic [STAT_W-1:0]     stat_misses,
  output logic [STAT_W-1:0]     stat_timeouts
`endif
);

  localparam int unsigned LIM = fill_limit(K, FILL_TIMEOUT);
  localparam int unsigned CW  = $clog2(LIM + 1);

  req_state_t            state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic [LINE_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] in_val_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  mreq_q;
  logic                  mwe_q;
  logic [LINE_WIDTH-1:0] mwdata_q;
  logic                  fill_hit;
  logic                  fill_to;

  // ch1_hit is stale in the first fill cycle, so only later cycles count.
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign fill_hit = (cnt_q != '0) && ch1_hit;
  assign fill_to  = !fill_hit && (cnt_d >= CW'(LIM));

  // Request sequencing FSM; every output is a register set on transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= RESP_OK;
      addr_q      <= '0;
      in_val_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mreq_q      <= 1'b0;
      mwe_q       <= 1'b0;
      mwdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= RESP_OK;
      rd_q        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            addr_q  <= req_addr;
            if (req_we) begin
              mwdata_q <= req_wdata;
              mreq_q   <= 1'b1;
              mwe_q    <= 1'b1;
              state_q  <= S_WR_MEM;
            end else begin
              rd_q    <= 1'b1;
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          state_q <= S_LK_WAIT;
        end
        S_LK_WAIT: begin
          if (ch1_hit) begin
            rsp_data_q  <= ch1_out_val;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            mreq_q  <= 1'b1;
            mwe_q   <= 1'b0;
            state_q <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            mreq_q  <= 1'b0;
            state_q <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            in_val_q <= mem_rsp_data;
            wr_q     <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_FILL;
          end
        end
        S_WR_MEM: begin
          if (mem_req_ready) begin
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            in_val_q <= mwdata_q;
            wr_q     <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          cnt_q <= cnt_d;
          if (fill_hit || fill_to) begin
            wr_q        <= 1'b0;
            rsp_data_q  <= in_val_q;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= fill_hit ? RESP_OK : RESP_ERR;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign ch1_in_addr   = addr_q;
  assign ch1_in_val    = in_val_q;
  assign ch1_read      = rd_q;
  assign ch1_write     = wr_q;
  assign mem_req_valid = mreq_q;
  assign mem_req_we    = mwe_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = mwdata_q;

`ifdef CACHE_REQ_STATS_EN
  logic hit_ev;
  logic miss_ev;
  logic to_ev;

  assign hit_ev  = (state_q == S_LK_WAIT) && ch1_hit;
  assign miss_ev = (state_q == S_LK_WAIT) && !ch1_hit;
  assign to_ev   = (state_q == S_FILL) && fill_to;

  cache_req_stats u_stats (
    .clock_i    (clock),
    .reset_i    (reset),
    .hit_i      (hit_ev),
    .miss_i     (miss_ev),
    .timeout_i  (to_ev),
    .hits_o     (stat_hits),
    .misses_o   (stat_misses),
    .timeouts_o (stat_timeouts)
  );
`endif

endmodule
